// File: rtl/jtag_host.sv
// JTAG initiator: turns one high-level command (TAP reset, IR/DR scan, idle clocks)
// into a TCK/TMS/TDI waveform and returns the TDO bits captured during the shift.
module jtag_host #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               JTAG_TCK,
  output logic               JTAG_TMS,
  output logic               JTAG_TDI,
  input  logic               JTAG_TDO
);

  localparam int PH_W  = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int KW    = $clog2(MAX_LEN + 8);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {CMD_RESET, CMD_IR, CMD_DR, CMD_IDLE} cmd_e;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_e;

  state_e             state_q, state_d;
  cmd_e               typ_q, typ_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [KW-1:0]      k_q, k_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [KW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;

  // TCK budget of each segment; ones_n is the count of leading TMS=1 header bits.
  logic [KW-1:0] pre_n, shift_n, post_n, total_n, ones_n;
  logic          is_scan;

  always_comb begin
    pre_n   = '0;
    shift_n = '0;
    post_n  = '0;
    ones_n  = '0;
    is_scan = 1'b0;
    case (typ_q)
      CMD_RESET: begin
        pre_n  = KW'(6);
        ones_n = KW'(5);
      end
      CMD_IR: if (len_q != '0) begin
        pre_n   = KW'(4);
        ones_n  = KW'(2);
        shift_n = len_q;
        post_n  = KW'(2);
        is_scan = 1'b1;
      end
      CMD_DR: if (len_q != '0) begin
        pre_n   = KW'(3);
        ones_n  = KW'(1);
        shift_n = len_q;
        post_n  = KW'(2);
        is_scan = 1'b1;
      end
      default: shift_n = len_q;
    endcase
    total_n = pre_n + shift_n + post_n;
  end

  // NOTE: every next-state variable is defaulted to its current value first, so no
  // path through this block leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    ph_d    = ph_q;
    k_d     = k_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        typ_d   = cmd_e'(cmd_type);
        len_d   = (int'(cmd_len) > MAX_LEN) ? KW'(MAX_LEN) : KW'(cmd_len);
        data_d  = cmd_data;
        rsp_d   = '0;
        k_d     = '0;
        // Start as if a previous TCK just ended so the next edge launches TCK 0.
        ph_d    = PH_LAST;
        state_d = S_PRE;
      end
      S_PRE, S_SHIFT, S_POST: begin
        if (ph_q == PH_RISE) begin
          tck_d = 1'b1;
          ph_d  = ph_q + 1'b1;
          if (state_q == S_SHIFT && is_scan) rsp_d[idx_q] = JTAG_TDO;
        end else if (ph_q == PH_LAST) begin
          tck_d = 1'b0;
          tms_d = 1'b0;
          tdi_d = 1'b0;
          ph_d  = '0;
          if (k_q == total_n) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
            if (k_q < pre_n) begin
              state_d = S_PRE;
              tms_d   = (k_q < ones_n);
            end else if (k_q < pre_n + shift_n) begin
              state_d = S_SHIFT;
              idx_d   = IDX_W'(k_q - pre_n);
              if (is_scan) begin
                tms_d = (k_q == total_n - KW'(3));
                tdi_d = data_q[idx_d];
              end
            end else begin
              state_d = S_POST;
              tms_d   = (k_q == total_n - KW'(2));
            end
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of the others; the combinational block above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      typ_q   <= CMD_RESET;
      ph_q    <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      rsp_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rsp_q   <= rsp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // NOTE: the command data register is not reset; it is always loaded on accept
  // before any bit of it reaches TDI, so a reset term would only cost logic.
  always_ff @(posedge clk) data_q <= data_d;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_q;
  assign JTAG_TCK  = tck_q;
  assign JTAG_TMS  = tms_q;
  assign JTAG_TDI  = tdi_q;

endmodule
